// File: rtl/vec_decode_pkg.sv
// Shared types and decode helpers for the vector decode queue.
// Decoding is a pure function so the queue top stays a thin handshake wrapper.
package vec_decode_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    OPC_V_LOAD  = 7'h07,
    OPC_V_STORE = 7'h27,
    OPC_V_ARITH = 7'h57
  } vec_opcode_e;

  typedef enum logic [2:0] {
    F3_OPIVV = 3'b000,
    F3_OPFVV = 3'b001,
    F3_OPMVV = 3'b010,
    F3_OPIVI = 3'b011,
    F3_OPIVX = 3'b100,
    F3_OPFVF = 3'b101,
    F3_OPMVX = 3'b110,
    F3_CONF  = 3'b111
  } vec_func3_e;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_CONF  = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } vec_uop_class_e;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_WAIT = 1'b1
  } cfg_state_e;

  typedef struct packed {
    vec_uop_class_e    cls;
    logic [2:0]        func3;
    logic [5:0]        func6;
    logic [4:0]        vd;
    logic [4:0]        vs1;
    logic [4:0]        vs2;
    logic [4:0]        vs3;
    logic [XLEN-1:0]   imm;
    logic              vm;
    logic [2:0]        width;
    logic              mew;
    logic [2:0]        nf;
    logic [1:0]        mop;
    logic [XLEN-1:0]   scalar1;
    logic [XLEN-1:0]   scalar2;
    logic              illegal;
  } vec_uop_t;

  localparam int UOP_W = $bits(vec_uop_t);

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VRSUB = 6'b000011;
  localparam logic [5:0] F6_VMINU = 6'b000100;
  localparam logic [5:0] F6_VMIN  = 6'b000101;
  localparam logic [5:0] F6_VMAXU = 6'b000110;
  localparam logic [5:0] F6_VMAX  = 6'b000111;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;
  localparam logic [5:0] F6_VSLL  = 6'b100101;
  localparam logic [5:0] F6_VSRL  = 6'b101000;
  localparam logic [5:0] F6_VSRA  = 6'b101001;

  localparam logic [5:0] F6_VMULHU  = 6'b100100;
  localparam logic [5:0] F6_VMUL    = 6'b100101;
  localparam logic [5:0] F6_VMULHSU = 6'b100110;
  localparam logic [5:0] F6_VMULH   = 6'b100111;
  localparam logic [5:0] F6_VMADD   = 6'b101001;
  localparam logic [5:0] F6_VNMSUB  = 6'b101011;
  localparam logic [5:0] F6_VMACC   = 6'b101101;
  localparam logic [5:0] F6_VNMSAC  = 6'b101111;

  localparam logic [7:0][5:0] OPM_F6_LIST = {
    F6_VMUL, F6_VMULH, F6_VMULHU, F6_VMULHSU,
    F6_VMACC, F6_VNMSAC, F6_VMADD, F6_VNMSUB
  };

  function automatic logic is_vec_opcode(input logic [6:0] opc);
    return (opc == OPC_V_ARITH) || (opc == OPC_V_LOAD) || (opc == OPC_V_STORE);
  endfunction

  // Integer ops: reverse-subtract has no VV form, sub/min/max have no VI form.
  function automatic logic opi_legal(input logic [2:0] f3, input logic [5:0] f6);
    logic ok;
    case (f6)
      F6_VADD:                                     ok = 1'b1;
      F6_VSUB, F6_VMINU, F6_VMIN, F6_VMAXU, F6_VMAX: ok = (f3 != F3_OPIVI);
      F6_VRSUB:                                    ok = (f3 != F3_OPIVV);
      F6_VAND, F6_VOR, F6_VXOR:                    ok = 1'b1;
      F6_VSLL, F6_VSRL, F6_VSRA:                   ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic opm_legal(input logic [5:0] f6);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hit = hit | (OPM_F6_LIST[i] == f6);
    end
    return hit;
  endfunction

  function automatic logic is_shift(input logic [5:0] f6);
    return (f6 == F6_VSLL) || (f6 == F6_VSRL) || (f6 == F6_VSRA);
  endfunction

  function automatic vec_uop_t decode_inst(input logic [XLEN-1:0] inst,
                                           input logic [XLEN-1:0] rs1,
                                           input logic [XLEN-1:0] rs2);
    vec_uop_t u;
    u       = '0;
    u.cls   = CLS_ARITH;
    u.func3 = inst[14:12];
    u.func6 = inst[31:26];
    u.vd    = inst[11:7];
    u.vs1   = inst[19:15];
    u.vs2   = inst[24:20];
    u.vm    = inst[25];
    case (inst[6:0])
      OPC_V_LOAD, OPC_V_STORE: begin
        u.cls     = (inst[6:0] == OPC_V_LOAD) ? CLS_LOAD : CLS_STORE;
        u.width   = inst[14:12];
        u.mew     = inst[28];
        u.nf      = inst[31:29];
        u.mop     = inst[27:26];
        u.scalar1 = rs1;
        // Indexed modes carry the index register in vs2, so no scalar stride.
        if (inst[26]) u.scalar2 = '0;
        else if (inst[27]) u.scalar2 = rs2;
        else u.scalar2 = XLEN'(inst[24:20]);
        if (inst[6:0] == OPC_V_STORE) u.vs3 = inst[11:7];
        else u.vs3 = 5'd0;
      end
      OPC_V_ARITH: begin
        if (inst[14:12] == F3_CONF) begin
          u.cls = CLS_CONF;
          if (!inst[31]) begin
            u.scalar1 = rs1;
            u.scalar2 = XLEN'(inst[30:20]);
          end else if (inst[30]) begin
            u.scalar1 = XLEN'(inst[19:15]);
            u.scalar2 = XLEN'(inst[29:20]);
          end else begin
            u.scalar1 = rs1;
            u.scalar2 = rs2;
            u.illegal = (inst[29:25] != 5'd0);
          end
        end else begin
          case (inst[14:12])
            F3_OPIVV: u.illegal = !opi_legal(inst[14:12], inst[31:26]);
            F3_OPIVX: begin
              u.vs1     = 5'd0;
              u.scalar1 = rs1;
              u.illegal = !opi_legal(inst[14:12], inst[31:26]);
            end
            F3_OPIVI: begin
              u.vs1 = 5'd0;
              if (is_shift(inst[31:26])) u.imm = XLEN'(inst[19:15]);
              else u.imm = {{(XLEN-5){inst[19]}}, inst[19:15]};
              u.illegal = !opi_legal(inst[14:12], inst[31:26]);
            end
            F3_OPMVV: begin
              u.vs3     = inst[11:7];
              u.illegal = !opm_legal(inst[31:26]);
            end
            F3_OPMVX: begin
              u.vs1     = 5'd0;
              u.scalar1 = rs1;
              u.illegal = !opm_legal(inst[31:26]);
            end
            default: u.illegal = 1'b1;
          endcase
        end
      end
      default: u.illegal = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/vec_uop_fifo.sv
// In-order pointer/count FIFO; flush empties it and overrides push/pop.
// Pushes while full and pops while empty are dropped.
module vec_uop_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  T                 i_wdata,
  output T                 o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == CNT_W'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & !o_full & !i_flush;
  assign w_do_pop  = i_pop & !o_empty & !i_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/vec_decode_queue.sv
// Vector decode front-end: decodes accepted instructions into uops, queues them,
// and holds issue after a CONF uop until the CSR unit acknowledges it.
module vec_decode_queue
  import vec_decode_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [XLEN-1:0]  vec_inst,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             is_vec,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [UOP_W-1:0] uop,
  input  logic             csr_ack,
  output logic             cfg_pending,
  output logic [CNT_W-1:0] count
);

  vec_uop_t   w_dec_uop;
  vec_uop_t   w_head_uop;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_head_conf;
  cfg_state_e r_cfg_state;
  cfg_state_e w_cfg_next;

  assign is_vec      = is_vec_opcode(vec_inst[6:0]);
  assign inst_ready  = !w_full;
  assign w_dec_uop   = decode_inst(vec_inst, rs1_data, rs2_data);
  assign w_push      = inst_valid & inst_ready & is_vec;
  assign cfg_pending = (r_cfg_state == CFG_WAIT);
  assign uop_valid   = !w_empty & !cfg_pending;
  assign w_pop       = uop_valid & uop_ready;
  assign w_head_conf = (w_head_uop.cls == CLS_CONF);
  assign uop         = w_head_uop;

  vec_uop_fifo #(
    .DEPTH (DEPTH),
    .T     (vec_uop_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_dec_uop),
    .o_rdata (w_head_uop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cfg_state <= CFG_IDLE;
    else r_cfg_state <= w_cfg_next;
  end

  // A CONF pop outranks a same-cycle ack: that ack belongs to an older CONF.
  always_comb begin
    w_cfg_next = r_cfg_state;
    if (flush) w_cfg_next = CFG_IDLE;
    else if (w_pop && w_head_conf) w_cfg_next = CFG_WAIT;
    else if (csr_ack) w_cfg_next = CFG_IDLE;
    else w_cfg_next = r_cfg_state;
  end

endmodule

// File: tb/tb_vec_decode_queue.sv
// Bench for vec_decode_queue: constant decode table, hand-written corner sequences,
// and random traffic checked every cycle against a queue-based reference model.
module tb_vec_decode_queue;
  import vec_decode_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset, flush, inst_valid, uop_ready, csr_ack;
  logic [31:0]      vec_inst, rs1_data, rs2_data;
  logic             inst_ready, is_vec, uop_valid, cfg_pending;
  logic [UOP_W-1:0] uop;
  logic [CNT_W-1:0] count;

  int n_vec  = 0;
  int n_miss = 0;

  vec_uop_t m_q[$];
  bit       m_pend;

  typedef struct {
    logic [31:0] inst, r1, r2;
    logic [1:0]  cls;
    logic        ill;
    logic [4:0]  vs1, vs3;
    logic [31:0] imm, s1, s2;
  } vec_t;
  vec_t tbl[$];

  vec_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .vec_inst(vec_inst), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .is_vec(is_vec), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop(uop), .csr_ack(csr_ack),
    .cfg_pending(cfg_pending), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_uop(input string nm, input vec_uop_t act, input vec_uop_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] op_v(input logic [5:0] f6, input logic [4:0] vs2,
                                       input logic [4:0] vs1, input logic [2:0] f3,
                                       input logic [4:0] vd);
    return {f6, 1'b1, vs2, vs1, f3, vd, 7'h57};
  endfunction

  function automatic logic [31:0] mk_mem(input logic [6:0] opc, input logic [1:0] mop,
                                         input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] width, input logic [4:0] vd);
    return {3'b000, 1'b0, mop, 1'b1, rs2, rs1, width, vd, opc};
  endfunction

  function automatic bit m_isvec(input logic [31:0] inst);
    return inst[6:0] inside {7'h57, 7'h07, 7'h27};
  endfunction

  // Reference decode written from the instruction-set rules as legal-value sets.
  function automatic vec_uop_t m_decode(input logic [31:0] inst, input logic [31:0] r1,
                                        input logic [31:0] r2);
    vec_uop_t u;
    logic [5:0] f6;
    logic [2:0] f3;
    logic [6:0] opc;
    bit legal, vx, vi;
    f6 = inst[31:26]; f3 = inst[14:12]; opc = inst[6:0];
    u = '0;
    u.func3 = f3; u.func6 = f6; u.vd = inst[11:7]; u.vs1 = inst[19:15];
    u.vs2 = inst[24:20]; u.vm = inst[25];
    if (opc == 7'h07 || opc == 7'h27) begin
      if (opc == 7'h07) u.cls = CLS_LOAD; else u.cls = CLS_STORE;
      u.nf = inst[31:29]; u.mew = inst[28]; u.mop = inst[27:26]; u.width = f3;
      u.scalar1 = r1;
      case (inst[27:26])
        2'b10:   u.scalar2 = r2;
        2'b00:   u.scalar2 = {27'd0, inst[24:20]};
        default: u.scalar2 = 32'd0;
      endcase
      if (opc == 7'h27) u.vs3 = inst[11:7];
    end else if (f3 == 3'b111) begin
      u.cls = CLS_CONF;
      case (inst[31:30])
        2'b11:   begin u.scalar1 = {27'd0, inst[19:15]}; u.scalar2 = {22'd0, inst[29:20]}; end
        2'b10:   begin u.scalar1 = r1; u.scalar2 = r2; u.illegal = (inst[29:25] != 5'd0); end
        default: begin u.scalar1 = r1; u.scalar2 = {21'd0, inst[30:20]}; end
      endcase
    end else begin
      u.cls = CLS_ARITH;
      vx = (f3 == 3'b100) || (f3 == 3'b110);
      vi = (f3 == 3'b011);
      if (vx || vi) u.vs1 = 5'd0;
      if (vx) u.scalar1 = r1;
      if (vi) begin
        if (f6 inside {6'b100101, 6'b101000, 6'b101001}) u.imm = {27'd0, inst[19:15]};
        else u.imm = {{27{inst[19]}}, inst[19:15]};
      end
      if (f3 == 3'b010) u.vs3 = inst[11:7];
      case (f3)
        3'b000: legal = f6 inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A,
                                   6'h0B, 6'h25, 6'h28, 6'h29};
        3'b100: legal = f6 inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09,
                                   6'h0A, 6'h0B, 6'h25, 6'h28, 6'h29};
        3'b011: legal = f6 inside {6'h00, 6'h03, 6'h09, 6'h0A, 6'h0B, 6'h25, 6'h28, 6'h29};
        3'b010, 3'b110: legal = f6 inside {6'h24, 6'h25, 6'h26, 6'h27, 6'h29, 6'h2B,
                                           6'h2D, 6'h2F};
        default: legal = 1'b0;
      endcase
      u.illegal = !legal;
    end
    return u;
  endfunction

  // One clock: drive at negedge, check against model, advance model across the edge.
  task automatic cycle(input bit fl, input bit iv, input logic [31:0] ins,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input bit ur, input bit ack);
    bit ev, er, pop, push, hc;
    flush = fl; inst_valid = iv; vec_inst = ins; rs1_data = r1; rs2_data = r2;
    uop_ready = ur; csr_ack = ack;
    #1;
    er = (m_q.size() < DEPTH);
    ev = (m_q.size() != 0) && !m_pend;
    chk("count", 64'(count), 64'(m_q.size()));
    chk("inst_ready", 64'(inst_ready), 64'(er));
    chk("uop_valid", 64'(uop_valid), 64'(ev));
    chk("cfg_pending", 64'(cfg_pending), 64'(m_pend));
    chk("is_vec", 64'(is_vec), 64'(m_isvec(ins)));
    if (m_q.size() != 0) chk_uop("head_uop", uop, m_q[0]);
    if (fl) begin
      m_q.delete();
      m_pend = 1'b0;
    end else begin
      pop  = ev && ur;
      push = iv && er && m_isvec(ins);
      hc   = 1'b0;
      if (pop) begin
        hc = (m_q[0].cls == CLS_CONF);
        void'(m_q.pop_front());
      end
      if (push) m_q.push_back(m_decode(ins, r1, r2));
      if (hc) m_pend = 1'b1;
      else if (ack) m_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] ins, input bit ur);
    cycle(1'b0, 1'b1, ins, 32'h0000_1111, 32'h0000_2222, ur, 1'b0);
  endtask

  task automatic idle(input bit ur, input bit ack);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, ur, ack);
  endtask

  task automatic add_vec(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [1:0] cls, input logic ill, input logic [4:0] vs1,
                         input logic [4:0] vs3, input logic [31:0] imm,
                         input logic [31:0] s1, input logic [31:0] s2);
    vec_t v;
    v.inst = inst; v.r1 = r1; v.r2 = r2; v.cls = cls; v.ill = ill; v.vs1 = vs1;
    v.vs3 = vs3; v.imm = imm; v.s1 = s1; v.s2 = s2;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] vsetvli, vadd, ins;
    vec_uop_t    h;
    logic [5:0]  f6_pool [8];
    f6_pool = '{6'h00, 6'h02, 6'h03, 6'h25, 6'h28, 6'h29, 6'h27, 6'h2D};
    vsetvli = {1'b0, 11'h0D0, 5'd17, 3'b111, 5'd1, 7'h57};
    vadd    = 32'h0220_8057;

    reset = 1'b1; flush = 1'b0; inst_valid = 1'b0; uop_ready = 1'b0; csr_ack = 1'b0;
    vec_inst = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    m_pend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_cfg_pending", 64'(cfg_pending), 64'd0);
    chk("rst_uop_valid", 64'(uop_valid), 64'd0);
    chk("rst_inst_ready", 64'(inst_ready), 64'd1);
    @(negedge clk);

    // cls: 0 ARITH, 1 CONF, 2 LOAD, 3 STORE
    add_vec(vadd, 32'd0, 32'd0, 2'd0, 1'b0, 5'd1, 5'd0, 32'd0, 32'd0, 32'd0);
    add_vec(op_v(6'b000000, 5'd2, 5'h1F, 3'b011, 5'd3), 32'd0, 32'd0,
            2'd0, 1'b0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    add_vec(op_v(6'b100101, 5'd4, 5'h1F, 3'b011, 5'd7), 32'd0, 32'd0,
            2'd0, 1'b0, 5'd0, 5'd0, 32'h0000_001F, 32'd0, 32'd0);
    add_vec(op_v(6'b000000, 5'd2, 5'd9, 3'b100, 5'd1), 32'h0000_1234, 32'd0,
            2'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'h0000_1234, 32'd0);
    add_vec(op_v(6'b100101, 5'd2, 5'd3, 3'b010, 5'd5), 32'd0, 32'd0,
            2'd0, 1'b0, 5'd3, 5'd5, 32'd0, 32'd0, 32'd0);
    add_vec(op_v(6'b000000, 5'd2, 5'd3, 3'b010, 5'd6), 32'd0, 32'd0,
            2'd0, 1'b1, 5'd3, 5'd6, 32'd0, 32'd0, 32'd0);
    add_vec(op_v(6'b000000, 5'd2, 5'd3, 3'b001, 5'd1), 32'd0, 32'd0,
            2'd0, 1'b1, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0);
    add_vec(op_v(6'b000011, 5'd2, 5'd3, 3'b000, 5'd1), 32'd0, 32'd0,
            2'd0, 1'b1, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0);
    add_vec(op_v(6'b100111, 5'd2, 5'd3, 3'b110, 5'd4), 32'd5, 32'd0,
            2'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd5, 32'd0);
    add_vec(vsetvli, 32'd17, 32'd0, 2'd1, 1'b0, 5'd17, 5'd0, 32'd0, 32'd17, 32'h0000_00D0);
    add_vec({2'b11, 10'h3C5, 5'd9, 3'b111, 5'd2, 7'h57}, 32'h0000_BEEF, 32'd0,
            2'd1, 1'b0, 5'd9, 5'd0, 32'd0, 32'd9, 32'h0000_03C5);
    add_vec({7'b1000000, 5'd4, 5'd5, 3'b111, 5'd3, 7'h57}, 32'hAAAA_0000, 32'h0000_0055,
            2'd1, 1'b0, 5'd5, 5'd0, 32'd0, 32'hAAAA_0000, 32'h0000_0055);
    add_vec(mk_mem(7'h07, 2'b10, 5'd4, 5'd6, 3'b110, 5'd8), 32'h0000_1000, 32'h0000_0040,
            2'd2, 1'b0, 5'd6, 5'd0, 32'd0, 32'h0000_1000, 32'h0000_0040);
    add_vec(mk_mem(7'h27, 2'b00, 5'd8, 5'd6, 3'b000, 5'd12), 32'h0000_2000, 32'h0000_0099,
            2'd3, 1'b0, 5'd6, 5'd12, 32'd0, 32'h0000_2000, 32'h0000_0008);
    add_vec(mk_mem(7'h07, 2'b01, 5'd10, 5'd6, 3'b111, 5'd2), 32'h0000_3000, 32'h0000_0077,
            2'd2, 1'b0, 5'd6, 5'd0, 32'd0, 32'h0000_3000, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(1'b0, 1'b1, tbl[i].inst, tbl[i].r1, tbl[i].r2, 1'b0, 1'b0);
      h = uop;
      chk("tbl_uop_valid", 64'(uop_valid), 64'd1);
      chk("tbl_count", 64'(count), 64'd1);
      chk("tbl_cls", 64'(h.cls), 64'(tbl[i].cls));
      chk("tbl_illegal", 64'(h.illegal), 64'(tbl[i].ill));
      chk("tbl_vs1", 64'(h.vs1), 64'(tbl[i].vs1));
      chk("tbl_vs3", 64'(h.vs3), 64'(tbl[i].vs3));
      chk("tbl_imm", 64'(h.imm), 64'(tbl[i].imm));
      chk("tbl_scalar1", 64'(h.scalar1), 64'(tbl[i].s1));
      chk("tbl_scalar2", 64'(h.scalar2), 64'(tbl[i].s2));
      idle(1'b1, 1'b0);
      chk("tbl_cfg_after_pop", 64'(cfg_pending), 64'(tbl[i].cls == 2'd1));
      idle(1'b0, 1'b1);
    end

    // CONF followed by VADD: VADD held until ack, issuable the cycle after.
    push(vsetvli, 1'b1);
    push(vadd, 1'b1);
    chk("cfg_hold_valid", 64'(uop_valid), 64'd0);
    chk("cfg_hold_pending", 64'(cfg_pending), 64'd1);
    chk("cfg_hold_count", 64'(count), 64'd1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("cfg_still_held", 64'(uop_valid), 64'd0);
    idle(1'b0, 1'b1);
    h = uop;
    chk("cfg_release_valid", 64'(uop_valid), 64'd1);
    chk("cfg_release_vs2", 64'(h.vs2), 64'd2);
    idle(1'b1, 1'b0);

    // CONF pop coincident with ack leaves cfg_pending set.
    push(vsetvli, 1'b0);
    idle(1'b1, 1'b1);
    chk("pop_ack_same_cycle", 64'(cfg_pending), 64'd1);
    idle(1'b0, 1'b1);
    chk("ack_clears", 64'(cfg_pending), 64'd0);

    // Fill to full, then no pop-through from full.
    for (int i = 0; i < 4; i++) push(vadd, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_inst_ready", 64'(inst_ready), 64'd0);
    push(vadd, 1'b1);
    chk("full_pop_no_push", 64'(count), 64'd3);
    push(vadd, 1'b1);
    chk("push_pop_count", 64'(count), 64'd3);
    push(vadd, 1'b0);
    chk("refill_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);

    // Illegal OPMVV still queued; scalar opcode handshakes but is not queued.
    push(op_v(6'b000000, 5'd1, 5'd1, 3'b010, 5'd1), 1'b0);
    h = uop;
    chk("illegal_queued", 64'(h.illegal), 64'd1);
    push(32'h0000_0033, 1'b0);
    chk("nonvec_count", 64'(count), 64'd1);
    idle(1'b1, 1'b0);

    // Flush with three queued and a CONF outstanding, racing a push.
    push(vsetvli, 1'b0);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(vadd, 1'b0);
    chk("preflush_count", 64'(count), 64'd3);
    chk("preflush_pending", 64'(cfg_pending), 64'd1);
    cycle(1'b1, 1'b1, vadd, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_pending", 64'(cfg_pending), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 4))
        0: ins = {f6_pool[$urandom_range(0, 7)], ins[25:7], 7'h57};
        1: ins = {ins[31:7], 7'h57};
        2: ins = {ins[31:7], 7'h07};
        3: ins = {ins[31:7], 7'h27};
        default: ins = {ins[31:7], 7'h33};
      endcase
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ins, $urandom, $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) push(vadd, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_inst_ready", 64'(inst_ready), 64'd1);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_uop_valid", 64'(uop_valid), 64'd0);
    chk("async_rst_pending", 64'(cfg_pending), 64'd0);
    m_q.delete();
    m_pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push(vadd, 1'b0);
    idle(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
